// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
// Shares one 8-bit SPI byte driver (start pulse in, active-low enable and
// received byte out) among N_REQ requesters.
// - Picks requesters round-robin.
// - Runs the start / wait-for-busy / wait-for-done handshake with the driver.
// - Drives one active-low chip select per requester.
// - Returns the received byte, or an error flag on timeout.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req, req_data     per-requester request level and tx byte (slice i = [8i+7:8i])
//   req_ack           one-cycle pulse: request accepted, tx byte latched
//   resp_valid        one-cycle pulse per requester with resp_data / resp_err
//   cs_n              per-slave chip select, active low
//   busy              high whenever the sequencer is not idle
//   spi_start         start pulse to the driver
//   spi_tx_data       byte handed to the driver
//   spi_en_n          driver enable, low while shifting
//   spi_rx_data       byte received by the driver
module spi_txn_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 8,
    parameter int XFER_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ack,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [7:0]           resp_data,
    output logic                 resp_err,
    output logic [N_REQ-1:0]     cs_n,
    output logic                 busy,
    output logic                 spi_start,
    output logic [7:0]           spi_tx_data,
    input  logic                 spi_en_n,
    input  logic [7:0]           spi_rx_data
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int T_MAX = (XFER_TIMEOUT > BUSY_TIMEOUT) ? XFER_TIMEOUT : BUSY_TIMEOUT;
    localparam int TMR_W = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] BUSY_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] XFER_LAST = TMR_W'(XFER_TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [N_REQ-1:0] ALL_ONES  = {N_REQ{1'b1}};
    localparam logic [N_REQ-1:0] ALL_ZEROS = {N_REQ{1'b0}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [TMR_W-1:0]   timer_r;

    logic [IDX_W-1:0]   winner_s;
    logic [N_REQ-1:0]   winner_oh_s;
    logic [N_REQ-1:0]   grant_oh_s;
    logic [7:0]         tx_sel_s;

    // First set request bit strictly after 'last', wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = {IDX_W{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Round-robin winner, its one-hot form, and the current grant's one-hot form.
    always_comb begin
        winner_s    = rr_pick(req, last_grant_r);
        winner_oh_s = ONE_HOT0 << winner_s;
        grant_oh_s  = ONE_HOT0 << grant_r;
    end

    // Selects the winner's tx byte.
    always_comb begin
        tx_sel_s = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_s == IDX_W'(i)) begin
                tx_sel_s = req_data[8*i +: 8];
            end else begin
                tx_sel_s = tx_sel_s;
            end
        end
    end

    // Sequencer FSM. Every output is registered, and the pulse outputs default to 0 each cycle.
    // On the edge that enters RESP, resp_valid/resp_data/resp_err are loaded,
    // so they are visible during the RESP cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= {IDX_W{1'b0}};
            last_grant_r <= IDX_W'(N_REQ - 1);
            timer_r      <= {TMR_W{1'b0}};
            req_ack      <= ALL_ZEROS;
            resp_valid   <= ALL_ZEROS;
            resp_data    <= 8'h00;
            resp_err     <= 1'b0;
            cs_n         <= ALL_ONES;
            busy         <= 1'b0;
            spi_start    <= 1'b0;
            spi_tx_data  <= 8'h00;
        end else begin
            req_ack    <= ALL_ZEROS;
            resp_valid <= ALL_ZEROS;
            spi_start  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        grant_r     <= winner_s;
                        spi_tx_data <= tx_sel_s;
                        req_ack     <= winner_oh_s;
                        busy        <= 1'b1;
                        state_r     <= START;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                START: begin
                    spi_start <= 1'b1;
                    cs_n      <= ~grant_oh_s;
                    timer_r   <= {TMR_W{1'b0}};
                    state_r   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // The driver going busy takes priority over a timeout on the same cycle.
                    if (!spi_en_n) begin
                        timer_r <= {TMR_W{1'b0}};
                        state_r <= WAIT_DONE;
                    end else if (timer_r == BUSY_LAST) begin
                        resp_valid <= grant_oh_s;
                        resp_data  <= 8'h00;
                        resp_err   <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                WAIT_DONE: begin
                    // The rx byte is valid while enable is high right after the
                    // transfer, and completion takes priority over a timeout on the same cycle.
                    if (spi_en_n) begin
                        resp_valid <= grant_oh_s;
                        resp_data  <= spi_rx_data;
                        resp_err   <= 1'b0;
                        state_r    <= RESP;
                    end else if (timer_r == XFER_LAST) begin
                        state_r <= DRAIN;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
                    end
                end
                DRAIN: begin
                    // Keep the slave selected until the hung driver lets go.
                    if (spi_en_n) begin
                        resp_valid <= grant_oh_s;
                        resp_data  <= 8'h00;
                        resp_err   <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                RESP: begin
                    last_grant_r <= grant_r;
                    cs_n         <= ALL_ONES;
                    busy         <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    cs_n    <= ALL_ONES;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed testbench for spi_txn_arbiter. The bench models the SPI driver
// inline by toggling spi_en_n and spi_rx_data. It checks outputs on the
// falling clock edge against hand-computed values.
module tb_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  resp_valid;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic [3:0]  cs_n;
    logic        busy;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic        spi_en_n;
    logic [7:0]  spi_rx_data;

    int checks   = 0;
    int failures = 0;

    spi_txn_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(8), .XFER_TIMEOUT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .cs_n        (cs_n),
        .busy        (busy),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_en_n    (spi_en_n),
        .spi_rx_data (spi_rx_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int g);
        logic [3:0] v;
        v = 4'b0001 << g;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise req, wait (bounded) for the ack, then check the start cycle.
    // The task returns on the falling edge where spi_start is visible.
    task automatic get_grant(input logic [3:0] rq, input bit hold, input int g,
                             input logic [7:0] exp_tx);
        int n;
        logic [3:0] csx;
        n   = 0;
        csx = ~oh(g);
        req = rq;
        @(negedge clk);
        while (req_ack == 4'b0000 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("ack", {28'h0, req_ack}, {28'h0, oh(g)});
        chk("busy_on", {31'h0, busy}, 32'h1);
        if (!hold) req = 4'b0000;
        @(negedge clk);
        chk("start", {31'h0, spi_start}, 32'h1);
        chk("tx", {24'h0, spi_tx_data}, {24'h0, exp_tx});
        chk("cs_sel", {28'h0, cs_n}, {28'h0, csx});
    endtask

    // Driver model: go busy after bdly falling edges, then shift for edly
    // falling edges, then release with rx. Checks the response and the idle state after it.
    task automatic finish(input int g, input logic [7:0] rx, input int bdly, input int edly);
        logic [3:0] csx;
        csx = ~oh(g);
        repeat (bdly) @(negedge clk);
        spi_en_n = 1'b0;
        repeat (edly) @(negedge clk);
        chk("cs_mid", {28'h0, cs_n}, {28'h0, csx});
        spi_en_n    = 1'b1;
        spi_rx_data = rx;
        @(negedge clk);
        chk("resp_valid", {28'h0, resp_valid}, {28'h0, oh(g)});
        chk("resp_data", {24'h0, resp_data}, {24'h0, rx});
        chk("resp_err", {31'h0, resp_err}, 32'h0);
        chk("cs_sel_resp", {28'h0, cs_n}, {28'h0, csx});
        @(negedge clk);
        chk("cs_idle", {28'h0, cs_n}, 32'hF);
        chk("resp_clr", {28'h0, resp_valid}, 32'h0);
    endtask

    initial begin
        int n;
        int bad;
        rst         = 1'b1;
        req         = 4'b0000;
        req_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        spi_en_n    = 1'b1;
        spi_rx_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_cs", {28'h0, cs_n}, 32'hF);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_ack", {28'h0, req_ack}, 32'h0);
        chk("rst_resp", {28'h0, resp_valid}, 32'h0);
        chk("rst_start", {31'h0, spi_start}, 32'h0);
        chk("rst_tx", {24'h0, spi_tx_data}, 32'h0);
        chk("rst_rdata", {24'h0, resp_data}, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        rst = 1'b0;

        // Round-robin with all requests held: the grant order is 0,1,2,3.
        get_grant(4'b1111, 1'b1, 0, 8'h11); finish(0, 8'hA0, 0, 3);
        get_grant(4'b1111, 1'b1, 1, 8'h22); finish(1, 8'hA1, 0, 3);
        get_grant(4'b1111, 1'b1, 2, 8'h33); finish(2, 8'hA2, 0, 3);
        get_grant(4'b1111, 1'b1, 3, 8'h44); finish(3, 8'hA3, 0, 3);
        // Wrap and skip after last=3: the grant order is 0,2,0.
        get_grant(4'b0101, 1'b1, 0, 8'h11); finish(0, 8'hB0, 0, 2);
        get_grant(4'b0101, 1'b1, 2, 8'h33); finish(2, 8'hB2, 0, 2);
        get_grant(4'b0101, 1'b0, 0, 8'h11); finish(0, 8'hB4, 0, 2);

        // Single request from requester 2: tx A5, echo 3C, cs_n 1011.
        req_data[23:16] = 8'hA5;
        get_grant(4'b0100, 1'b0, 2, 8'hA5); finish(2, 8'h3C, 0, 4);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // Busy timeout: the driver never goes busy, so the response comes 8 cycles after start.
        get_grant(4'b0010, 1'b0, 1, 8'h22);
        n = 0;
        while (resp_valid == 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bt_latency", n, 8);
        chk("bt_valid", {28'h0, resp_valid}, 32'h2);
        chk("bt_err", {31'h0, resp_err}, 32'h1);
        chk("bt_data", {24'h0, resp_data}, 32'h0);
        @(negedge clk);
        chk("bt_cs_idle", {28'h0, cs_n}, 32'hF);
        // The next request proceeds normally.
        get_grant(4'b1000, 1'b0, 3, 8'h44); finish(3, 8'hC3, 0, 5);

        // Hung transfer: enable is held low 100 cycles, and the response follows its release.
        get_grant(4'b0001, 1'b0, 0, 8'h11);
        spi_en_n    = 1'b0;
        spi_rx_data = 8'h77;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (resp_valid != 4'b0000 || cs_n != 4'b1110 || busy != 1'b1) bad++;
        end
        chk("hung_hold", bad, 0);
        spi_en_n = 1'b1;
        @(negedge clk);
        chk("hung_valid", {28'h0, resp_valid}, 32'h1);
        chk("hung_err", {31'h0, resp_err}, 32'h1);
        chk("hung_data", {24'h0, resp_data}, 32'h0);
        @(negedge clk);
        chk("hung_cs_idle", {28'h0, cs_n}, 32'hF);

        // Completion on the WAIT_DONE timeout cycle wins.
        get_grant(4'b0001, 1'b0, 0, 8'h11); finish(0, 8'h5A, 0, 64);
        // Busy on the WAIT_BUSY timeout cycle wins.
        get_grant(4'b0010, 1'b0, 1, 8'h22); finish(1, 8'h6B, 7, 3);

        // Reset during WAIT_DONE: idle outputs on the next edge and no response.
        get_grant(4'b0100, 1'b0, 2, 8'hA5);
        spi_en_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs", {28'h0, cs_n}, 32'hF);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_resp", {28'h0, resp_valid}, 32'h0);
        chk("mid_rst_start", {31'h0, spi_start}, 32'h0);
        rst      = 1'b0;
        spi_en_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid != 4'b0000 || busy != 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        // After reset, requester 0 wins first.
        get_grant(4'b1111, 1'b0, 0, 8'h11); finish(0, 8'h99, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one 8-bit SPI master (CPOL=1/CPHA=0 byte driver: start pulse in, active-low enable and received byte out) among N_REQ requesters.
- Arbitrates round-robin, sequences the start/wait/capture handshake with the driver, drives a per-requester chip select, and returns the received byte or an error.
- Sits between requester logic and the SPI driver instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 8, max clk cycles from spi_start until spi_en_n goes low.
- XFER_TIMEOUT, 64, max clk cycles with spi_en_n low before the transfer is declared hung.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  per-requester transaction request, level, held until req_ack.
- req_data  in  8*N_REQ  tx byte per requester; slice i = [8i+7:8i].
- req_ack  out  N_REQ  one-cycle pulse: request i accepted, tx byte latched.
- resp_valid  out  N_REQ  one-cycle pulse: response for requester i.
- resp_data  out  8  rx byte, valid with any resp_valid bit.
- resp_err  out  1  timeout flag, valid with any resp_valid bit.
- cs_n  out  N_REQ  per-slave chip select, active low.
- busy  out  1  high in any state but IDLE.
- spi_start  out  1  start pulse to driver.
- spi_tx_data  out  8  byte to driver.
- spi_en_n  in  1  driver enable, low while shifting.
- spi_rx_data  in  8  driver received byte.

Behaviour:
- Clocking and reset: one clock (clk); synchronous active-high reset (rst). All state updates on posedge clk.
- Reset values:
  - state=IDLE; last_grant=N_REQ-1, so requester 0 wins first.
  - req_ack=0, resp_valid=0, resp_data=0, resp_err=0.
  - cs_n=all 1, spi_start=0, spi_tx_data=0, busy=0.
  - Timers=0.
- Reset mid-transaction: same values on the next edge. No response is issued for the aborted request.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP, DRAIN.
- IDLE:
  - If any req bit is set, the winner is the first set bit scanning from (last_grant+1) mod N_REQ upward with wrap.
  - Register grant=winner and spi_tx_data=req_data[winner]. Pulse req_ack[winner]. Go to START.
  - With no requests, stay in IDLE and leave last_grant unchanged.
- START:
  - spi_start=1 for exactly this cycle; cs_n[grant]=0; clear timer. Go to WAIT_BUSY.
- cs_n[grant] stays low from START through RESP (and DRAIN). At most one cs_n bit is low at any time.
- WAIT_BUSY:
  - Timer increments each cycle.
  - spi_en_n==0: clear timer, go to WAIT_DONE.
  - Otherwise, timer==BUSY_TIMEOUT-1: set err, go to RESP.
- WAIT_DONE:
  - Timer increments each cycle.
  - spi_en_n==1: capture resp_data=spi_rx_data this cycle (driver result is valid while enable is high right after transfer), err=0, go to RESP.
  - Otherwise, timer==XFER_TIMEOUT-1: set err, go to DRAIN.
- DRAIN: wait for spi_en_n==1, then go to RESP.
- RESP:
  - resp_valid[grant]=1 for one cycle with resp_data/resp_err.
  - When err=1, resp_data=0.
  - last_grant<=grant; cs_n all high on the next cycle; go to IDLE.
- Latency, no contention, driver responds normally: req_ack 1 cycle after req is seen in IDLE; spi_start 1 cycle after req_ack; resp_valid 1 cycle after spi_en_n rises.
- Minimum spacing: at least 2 cycles between consecutive spi_start pulses (RESP, IDLE), so the driver returns to idle.
- Request handling:
  - Requests deasserted before ack are simply not served.
  - req held after ack is treated as a new request in the next IDLE arbitration.
  - req_data is sampled only on the ack cycle.
- Simultaneous events:
  - spi_en_n rising on the timeout cycle in WAIT_DONE: completion wins (err=0).
  - In WAIT_BUSY, spi_en_n low on the timeout cycle: busy wins.
- Fairness: with all N_REQ requests continuously asserted, grants cycle 0,1,…,N_REQ-1,0, with no requester skipped.

Test Plan:
- Single request: req[2]=1, req_data slice2=0xA5, driver model echoes 0x3C → req_ack=4'b0100 one cycle, then spi_start with spi_tx_data=0xA5, cs_n=4'b1011 until resp, resp_valid=4'b0100 with resp_data=0x3C, resp_err=0.
- Round-robin: req=4'b1111 held for 5 transactions after reset → ack order 0,1,2,3,0; cs_n never has two low bits.
- Wrap/skip: last served 3, then req=4'b0101 → grant 0, then grant 2, then grant 0.
- Busy timeout: driver never lowers spi_en_n → resp_valid after 8 cycles in WAIT_BUSY, resp_err=1, resp_data=0x00; next request proceeds normally.
- Hung transfer: spi_en_n held low 100 cycles → state DRAIN after 64 cycles; resp_err=1 issued only after spi_en_n rises; cs_n stays low until then.
- Reset mid-transfer: assert rst during WAIT_DONE → next edge cs_n=all 1, busy=0, no resp_valid; first grant after release goes to requester 0.
